// File: rtl/adder_arbiter_pkg.sv
// adder_arbiter_pkg: shared constants and the round-robin pick for adder_arbiter.
package adder_arbiter_pkg;
  localparam int RSP_DEPTH = 2;
  localparam int ADD_LATENCY = 1;
  // First asserted valid at or after ptr, wrapping over n requesters (n <= 16).
  function automatic logic [15:0] rr_pick(input logic [15:0] valid, input logic [3:0] ptr, input logic [4:0] n);
    logic [4:0] j;
    rr_pick = '0;
    for (int i = 15; i >= 0; i--) begin
      j = {1'b0, ptr} + 5'(i);
      if (j >= n) j = j - n;
      if (5'(i) < n && valid[j[3:0]]) rr_pick = 16'(1) << j;
    end
  endfunction
endpackage

// File: rtl/adder_arbiter_adder.sv
// adder: registered WIDTH-bit adder with carry-out.
module adder #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_overflow
);
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) {o_overflow, o_sum} <= '0;
    else {o_overflow, o_sum} <= {1'b0, i_a} + {1'b0, i_b};
endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one registered adder among requesters,
// results returned in accept order through a 2-entry tagged response FIFO.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int REQUESTERS = 4,
  localparam int ID_W = (REQUESTERS > 2) ? $clog2(REQUESTERS) : 1
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [REQUESTERS-1:0]               i_req_valid,
  output logic [REQUESTERS-1:0]               o_req_ready,
  input  logic [REQUESTERS-1:0][WIDTH-1:0]    i_req_a,
  input  logic [REQUESTERS-1:0][WIDTH-1:0]    i_req_b,
  output logic                                o_rsp_valid,
  input  logic                                i_rsp_ready,
  output logic [ID_W-1:0]                     o_rsp_id,
  output logic [WIDTH-1:0]                    o_rsp_sum,
  output logic                                o_rsp_overflow
);
  logic [ID_W-1:0] r_ptr;
  logic r_inflight_valid;
  logic [ID_W-1:0] r_inflight_id;
  logic [1:0][ID_W-1:0] r_fifo_id;
  logic [1:0][WIDTH-1:0] r_fifo_sum;
  logic [1:0] r_fifo_ovf;
  logic r_rd, r_wr;
  logic [1:0] r_count;
  logic [15:0] w_pick;
  logic [1:0] w_credits;
  logic w_pop, w_allow, w_accept, w_ovf;
  logic [ID_W-1:0] w_win_id;
  logic [WIDTH-1:0] w_a, w_b, w_sum;
  assign w_pick = rr_pick(16'(i_req_valid), 4'(r_ptr), 5'(REQUESTERS));
  assign w_pop = o_rsp_valid && i_rsp_ready;
  assign w_credits = 2'(r_inflight_valid) + r_count;
  // A pop in the same cycle frees a slot for this cycle's accept.
  assign w_allow = int'(w_credits) < RSP_DEPTH || w_pop;
  assign o_req_ready = (w_allow && !i_rst) ? w_pick[REQUESTERS-1:0] : '0;
  assign w_accept = |o_req_ready;
  always_comb begin
    w_win_id = '0;
    w_a = '0;
    w_b = '0;
    for (int k = 0; k < REQUESTERS; k++) begin
      if (w_pick[k]) w_win_id = ID_W'(k);
      if (o_req_ready[k]) begin
        w_a = i_req_a[k];
        w_b = i_req_b[k];
      end
    end
  end
  adder #(.WIDTH(WIDTH)) u_adder (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_a(w_a),
    .i_b(w_b),
    .o_sum(w_sum),
    .o_overflow(w_ovf)
  );
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_ptr <= '0;
      r_inflight_valid <= 1'b0;
      r_inflight_id <= '0;
      r_fifo_id <= '0;
      r_fifo_sum <= '0;
      r_fifo_ovf <= '0;
      r_rd <= 1'b0;
      r_wr <= 1'b0;
      r_count <= '0;
    end else begin
      r_inflight_valid <= w_accept;
      r_inflight_id <= w_win_id;
      if (w_accept) r_ptr <= (w_win_id == ID_W'(REQUESTERS - 1)) ? '0 : w_win_id + 1'b1;
      if (r_inflight_valid) begin
        r_fifo_id[r_wr] <= r_inflight_id;
        r_fifo_sum[r_wr] <= w_sum;
        r_fifo_ovf[r_wr] <= w_ovf;
        r_wr <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      r_count <= r_count + 2'(r_inflight_valid) - 2'(w_pop);
    end
  assign o_rsp_valid = r_count != 2'd0;
  assign o_rsp_id = r_fifo_id[r_rd];
  assign o_rsp_sum = r_fifo_sum[r_rd];
  assign o_rsp_overflow = r_fifo_ovf[r_rd];
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed phases plus random traffic checked against a queue model.
module tb_adder_arbiter;
  localparam int W = 32;
  localparam int R = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [R-1:0] req_valid, req_ready;
  logic [R-1:0][W-1:0] req_a, req_b;
  logic rsp_valid, rsp_ready, rsp_ovf;
  logic [1:0] rsp_id;
  logic [W-1:0] rsp_sum;
  adder_arbiter #(.WIDTH(W), .REQUESTERS(R)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_req_valid(req_valid),
    .o_req_ready(req_ready),
    .i_req_a(req_a),
    .i_req_b(req_b),
    .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready),
    .o_rsp_id(rsp_id),
    .o_rsp_sum(rsp_sum),
    .o_rsp_overflow(rsp_ovf)
  );
  typedef struct {
    int id;
    logic [W-1:0] sum;
    logic ovf;
    int due;
  } rsp_t;
  rsp_t q[$];
  int m_ptr = 0;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int unsigned pct = 0;
  logic [R-1:0] mask = '0;
  logic rrdy = 1'b1;
  logic rv[R];
  logic [W-1:0] ra[R], rb[R];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] rnd_op();
    return ($urandom_range(3) == 0) ? {W{1'b1}} : W'($urandom);
  endfunction

  task automatic refill(input int win);
    if (win >= 0) rv[win] = 1'b0;
    for (int k = 0; k < R; k++)
      if (!rv[k] && mask[k] && $urandom_range(99) < pct) begin
        rv[k] = 1'b1;
        ra[k] = rnd_op();
        rb[k] = rnd_op();
      end
  endtask

  task automatic step();
    logic [R-1:0] exp_ready;
    logic exp_valid, pop, allow;
    logic [W:0] full;
    int win;
    @(negedge clk);
    for (int k = 0; k < R; k++) begin
      req_valid[k] = rv[k];
      req_a[k] = ra[k];
      req_b[k] = rb[k];
    end
    rsp_ready = rrdy;
    #1;
    exp_valid = q.size() > 0 && q[0].due <= cyc;
    pop = exp_valid && rrdy;
    allow = (q.size() - int'(pop)) < 2;
    win = -1;
    for (int i = 0; i < R; i++)
      if (win < 0 && rv[(m_ptr + i) % R]) win = (m_ptr + i) % R;
    exp_ready = (allow && win >= 0) ? R'(1) << win : '0;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
    if (exp_valid) begin
      chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
      chk("rsp_sum", 64'(rsp_sum), 64'(q[0].sum));
      chk("rsp_ovf", 64'(rsp_ovf), 64'(q[0].ovf));
    end
    if (pop) void'(q.pop_front());
    if (exp_ready != '0) begin
      full = {1'b0, ra[win]} + {1'b0, rb[win]};
      q.push_back('{win, full[W-1:0], full[W], cyc + 2});
      m_ptr = (win + 1) % R;
    end
    refill(exp_ready != '0 ? win : -1);
    cyc++;
  endtask

  initial begin
    for (int k = 0; k < R; k++) begin
      rv[k] = 1'b0;
      ra[k] = '0;
      rb[k] = '0;
    end
    req_valid = '1;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_valid", 64'(rsp_valid), 64'(0));
    chk("rst_id", 64'(rsp_id), 64'(0));
    chk("rst_sum", 64'(rsp_sum), 64'(0));
    chk("rst_ovf", 64'(rsp_ovf), 64'(0));
    req_valid = '0;
    rst = 1'b0;
    // Single request on requester 2: 5 + 7.
    rv[2] = 1'b1; ra[2] = 32'd5; rb[2] = 32'd7;
    repeat (4) step();
    // Carry-out.
    rv[0] = 1'b1; ra[0] = 32'hFFFF_FFFF; rb[0] = 32'd1;
    repeat (4) step();
    // Round-robin at full throughput.
    mask = '1; pct = 100;
    refill(-1);
    repeat (12) step();
    // Backpressure, then release.
    rrdy = 1'b0;
    repeat (6) step();
    rrdy = 1'b1;
    repeat (4) step();
    mask = '0;
    for (int i = 0; i < 20 && (q.size() > 0 || rv[0] || rv[1] || rv[2] || rv[3]); i++) step();
    chk("drain", 64'(q.size()), 64'(0));
    // Pointer to 3 via requester 2, then 1 and 3 valid: 3 wins, then 1.
    rv[2] = 1'b1; ra[2] = rnd_op(); rb[2] = rnd_op();
    step();
    rv[1] = 1'b1; ra[1] = rnd_op(); rb[1] = rnd_op();
    rv[3] = 1'b1; ra[3] = rnd_op(); rb[3] = rnd_op();
    repeat (5) step();
    // Random traffic with random consumer stalls.
    mask = '1; pct = 60;
    for (int i = 0; i < 400; i++) begin
      rrdy = $urandom_range(3) != 0;
      step();
    end
    // Reset with responses queued.
    rrdy = 1'b0; pct = 100;
    repeat (4) step();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    #1;
    chk("midrst_valid", 64'(rsp_valid), 64'(0));
    chk("midrst_ready", 64'(req_ready), 64'(0));
    chk("midrst_id", 64'(rsp_id), 64'(0));
    chk("midrst_sum", 64'(rsp_sum), 64'(0));
    chk("midrst_ovf", 64'(rsp_ovf), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_ptr = 0;
    mask = '0;
    rrdy = 1'b1;
    for (int k = 0; k < R; k++) rv[k] = 1'b0;
    rv[1] = 1'b1; ra[1] = rnd_op(); rb[1] = rnd_op();
    rv[3] = 1'b1; ra[3] = rnd_op(); rb[3] = rnd_op();
    repeat (6) step();
    chk("final_drain", 64'(q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
